// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the pipelined restoring divider.
// Signed-mode helpers are used only when DIVIDER_SIGNED_EN is defined.
package divider_pkg;

   // Widest operand the helpers handle; callers cast in and truncate out.
   localparam int unsigned MAXW = 64;

   typedef logic [MAXW-1:0] word_t;

   // Per-stage control payload; the data fields ride alongside as vectors
   // whose widths come from the instantiating module's parameters.
   typedef struct packed {
      logic vld;    // stage holds a live transaction
      logic zero;   // divisor was zero at the input
      logic neg_q;  // quotient must be negated at the output
      logic neg_r;  // remainder must be negated at the output
   } stage_ctl_t;

   // Quotient fill used for divide-by-zero results (all ones).
   function automatic word_t zero_fill();
      return '1;
   endfunction

   // Two's complement negation; low bits are correct for any truncation.
   function automatic word_t negate(input word_t v);
      return ~v + word_t'(1);
   endfunction

   // Magnitude of a value whose sign bit is supplied by the caller.
   function automatic word_t abs_val(input word_t v, input logic neg);
      return neg ? negate(v) : v;
   endfunction

endpackage

// File: rtl/divider_stage.sv
// divider_stage: one restoring-division step followed by its pipeline
// register. Holds all state while stall_i is high.
module divider_stage
   import divider_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned M  = 4,
   parameter int unsigned TW = 4
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall_i,
   input  stage_ctl_t    ctl_i,
   input  logic [M-1:0]  rem_i,
   input  logic [N-1:0]  qd_i,
   input  logic [M-1:0]  dsr_i,
   input  logic [TW-1:0] tag_i,
   output stage_ctl_t    ctl_o,
   output logic [M-1:0]  rem_o,
   output logic [N-1:0]  qd_o,
   output logic [M-1:0]  dsr_o,
   output logic [TW-1:0] tag_o
);

   // qd holds the unconsumed dividend bits in its upper part and the
   // quotient bits resolved so far in its lower part.
   stage_ctl_t    ctl_q;
   logic [M-1:0]  rem_q, rem_d;
   logic [N-1:0]  qd_q, qd_d;
   logic [M-1:0]  dsr_q;
   logic [TW-1:0] tag_q;
   logic [M:0]    rem_sh;
   logic          qbit;

   // Restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh = {rem_i, qd_i[N-1]};
      qbit   = (rem_sh >= {1'b0, dsr_i});
      rem_d  = M'(qbit ? (rem_sh - {1'b0, dsr_i}) : rem_sh);
      qd_d   = {qd_i[N-2:0], qbit};
   end

   // Stage register; everything freezes together on a global stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q <= '0;
         rem_q <= '0;
         qd_q  <= '0;
         dsr_q <= '0;
         tag_q <= '0;
      end else if (!stall_i) begin
         ctl_q <= ctl_i;
         rem_q <= rem_d;
         qd_q  <= qd_d;
         dsr_q <= dsr_i;
         tag_q <= tag_i;
      end
   end

   assign ctl_o = ctl_q;
   assign rem_o = rem_q;
   assign qd_o  = qd_q;
   assign dsr_o = dsr_q;
   assign tag_o = tag_q;

endmodule

// File: rtl/divider_pipe.sv
// divider_pipe: N-stage pipelined restoring divider with valid/ready flow
// control and tag pass-through. Define DIVIDER_SIGNED_EN to add the sign_i
// port and two's complement operation (magnitude core + output correction).
module divider_pipe
   import divider_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned M  = 4,
   parameter int unsigned TW = 4
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          data_rdy,
   output logic          in_ready,
   input  logic [N-1:0]  dividend,
   input  logic [M-1:0]  divisor,
   input  logic [TW-1:0] tag_in,
`ifdef DIVIDER_SIGNED_EN
   input  logic          sign_i,
`endif
   output logic          rdy,
   input  logic          out_ready,
   output logic [N-1:0]  merchant,
   output logic [M-1:0]  remainder,
   output logic          div_zero,
   output logic [TW-1:0] tag_out
);

   stage_ctl_t    ctl_in;
   logic [N-1:0]  qd_in;
   logic [M-1:0]  dsr_in;
   logic          stall;

   // Outputs of stage i live at index i; the last index feeds the ports.
   stage_ctl_t    ctl_s [N];
   logic [M-1:0]  rem_s [N];
   logic [N-1:0]  qd_s  [N];
   logic [M-1:0]  dsr_s [N];
   logic [TW-1:0] tag_s [N];

   // Input conditioning: zero detect and, in signed mode, operand magnitudes.
   // A zero divisor always passes the raw dividend so the remainder comes
   // back as the original low bits.
   always_comb begin
      ctl_in      = '0;
      ctl_in.vld  = data_rdy;
      ctl_in.zero = (divisor == '0);
      qd_in       = dividend;
      dsr_in      = divisor;
`ifdef DIVIDER_SIGNED_EN
      if (sign_i && (divisor != '0)) begin
         ctl_in.neg_q = dividend[N-1] ^ divisor[M-1];
         ctl_in.neg_r = dividend[N-1];
         qd_in        = N'(abs_val(word_t'(dividend), dividend[N-1]));
         dsr_in       = M'(abs_val(word_t'(divisor), divisor[M-1]));
      end
`endif
   end

   assign stall    = ctl_s[N-1].vld && !out_ready;
   assign in_ready = !stall;

   for (genvar i = 0; i < N; i++) begin : g_stage
      stage_ctl_t    c_i;
      logic [M-1:0]  r_i;
      logic [N-1:0]  q_i;
      logic [M-1:0]  d_i;
      logic [TW-1:0] t_i;

      if (i == 0) begin : g_src_in
         assign c_i = ctl_in;
         assign r_i = '0;
         assign q_i = qd_in;
         assign d_i = dsr_in;
         assign t_i = tag_in;
      end else begin : g_src_prev
         assign c_i = ctl_s[i-1];
         assign r_i = rem_s[i-1];
         assign q_i = qd_s[i-1];
         assign d_i = dsr_s[i-1];
         assign t_i = tag_s[i-1];
      end

      divider_stage #(.N(N), .M(M), .TW(TW)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .stall_i (stall),
         .ctl_i   (c_i),
         .rem_i   (r_i),
         .qd_i    (q_i),
         .dsr_i   (d_i),
         .tag_i   (t_i),
         .ctl_o   (ctl_s[i]),
         .rem_o   (rem_s[i]),
         .qd_o    (qd_s[i]),
         .dsr_o   (dsr_s[i]),
         .tag_o   (tag_s[i])
      );
   end

   assign rdy      = ctl_s[N-1].vld;
   assign div_zero = ctl_s[N-1].zero;
   assign tag_out  = tag_s[N-1];

   // Final correction: sign fix-up in signed mode and divide-by-zero fill.
   always_comb begin
      merchant  = qd_s[N-1];
      remainder = rem_s[N-1];
`ifdef DIVIDER_SIGNED_EN
      if (ctl_s[N-1].neg_q) merchant  = N'(negate(word_t'(qd_s[N-1])));
      if (ctl_s[N-1].neg_r) remainder = M'(negate(word_t'(rem_s[N-1])));
`endif
      if (ctl_s[N-1].zero) merchant = N'(zero_fill());
   end

endmodule
